bus_reg_array: RTL

BUS_REG_ARRAY -- requirements
Module: bus_reg_array

---
 rtl/bus_reg_pkg.sv | 15 +
 rtl/bus_reg_array_if.sv | 24 ++
 rtl/bus_reg_irq.sv | 45 ++++
 rtl/bus_reg_array.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/bus_reg_pkg.sv
// Shared definitions for the bus register array: IRQ register offsets
// (relative to NUM_REGS) and the decoded access type.
package bus_reg_pkg;

    localparam int IRQ_STATUS_OFS = 0;
    localparam int IRQ_ENABLE_OFS = 1;

    typedef enum logic [1:0] {
        ACC_NONE,
        ACC_WR,
        ACC_RD,
        ACC_ERR
    } acc_t;

endpackage

// File: rtl/bus_reg_array_if.sv
// Register bus: access strobe, direction, address and write data from the
// master; registered read data, read-valid and error pulses back.
interface bus_reg_array_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              i_Bus_CS;
    logic              i_Bus_Wr_Rd_n;
    logic [ADDR_W-1:0] i_Bus_Addr;
    logic [DATA_W-1:0] i_Bus_Wr_Data;
    logic [DATA_W-1:0] o_Bus_Rd_Data;
    logic              o_Bus_Rd_DV;
    logic              o_Bus_Err;

    modport master (
        output i_Bus_CS, i_Bus_Wr_Rd_n, i_Bus_Addr, i_Bus_Wr_Data,
        input  o_Bus_Rd_Data, o_Bus_Rd_DV, o_Bus_Err
    );

    modport slave (
        input  i_Bus_CS, i_Bus_Wr_Rd_n, i_Bus_Addr, i_Bus_Wr_Data,
        output o_Bus_Rd_Data, o_Bus_Rd_DV, o_Bus_Err
    );
endinterface

// File: rtl/bus_reg_irq.sv
// Interrupt block: sticky status with write-1-to-clear, enable mask and a
// registered interrupt request. Only instantiated when BUS_REG_IRQ_EN is set.
module bus_reg_irq #(
    parameter int DATA_W = 8
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic [DATA_W-1:0] i_Irq_Set,
    input  logic [DATA_W-1:0] i_W1c,
    input  logic              i_En_We,
    input  logic [DATA_W-1:0] i_En_Data,
    output logic [DATA_W-1:0] o_Status,
    output logic [DATA_W-1:0] o_Enable,
    output logic              o_Irq
);
    logic [DATA_W-1:0] r_status;
    logic [DATA_W-1:0] r_enable;
    logic              r_irq;
    logic [DATA_W-1:0] w_status_next;
    logic [DATA_W-1:0] w_enable_next;

    // Clear is applied before set so a same-cycle event is never lost.
    always_comb begin
        w_status_next = (r_status & ~i_W1c) | i_Irq_Set;
        w_enable_next = i_En_We ? i_En_Data : r_enable;
    end

    // Status/enable storage; the request looks at the next values so it
    // rises one cycle after the event or enabling write.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_status <= '0;
            r_enable <= '0;
            r_irq    <= 1'b0;
        end else begin
            r_status <= w_status_next;
            r_enable <= w_enable_next;
            r_irq    <= |(w_status_next & w_enable_next);
        end
    end

    assign o_Status = r_status;
    assign o_Enable = r_enable;
    assign o_Irq    = r_irq;
endmodule

// File: rtl/bus_reg_array.sv
// Bus-accessible register array: NUM_REGS general registers (bus-written,
// fabric-read) plus optional IRQ status/enable registers at NUM_REGS and
// NUM_REGS+1. Optional feature macro: BUS_REG_IRQ_EN.
module bus_reg_array
    import bus_reg_pkg::*;
#(
    parameter int                         DATA_W   = 8,
    parameter int                         NUM_REGS = 8,
    parameter int                         ADDR_W   = 4,
    parameter logic [NUM_REGS*DATA_W-1:0] INIT_VAL = '0,
    parameter logic [NUM_REGS-1:0]        RO_MASK  = '0
) (
    input  logic                         i_Bus_Clk,
    input  logic                         i_Bus_Rst,
    bus_reg_array_if.slave               bus,
    input  logic [NUM_REGS*DATA_W-1:0]   i_Regs,
    output logic [NUM_REGS*DATA_W-1:0]   o_Regs,
    output logic [NUM_REGS-1:0]          o_Wr_Stb,
    output logic [NUM_REGS-1:0]          o_Rd_Stb,
    input  logic [DATA_W-1:0]            i_Irq_Set,
    output logic                         o_Irq
);
`ifdef BUS_REG_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif
    localparam logic [ADDR_W-1:0] STAT_ADDR = ADDR_W'(NUM_REGS + IRQ_STATUS_OFS);
    localparam logic [ADDR_W-1:0] EN_ADDR   = ADDR_W'(NUM_REGS + IRQ_ENABLE_OFS);

    logic [NUM_REGS*DATA_W-1:0] r_regs;
    logic [NUM_REGS-1:0]        r_wr_stb;
    logic [NUM_REGS-1:0]        r_rd_stb;
    logic [DATA_W-1:0]          r_rd_data;
    logic                       r_rd_dv;
    logic                       r_err;

    logic [NUM_REGS-1:0]        w_hit;
    logic [NUM_REGS-1:0]        w_wr_hit;
    logic [NUM_REGS-1:0]        w_rd_hit;
    logic                       w_is_stat;
    logic                       w_is_en;
    logic                       w_rd_req;
    logic [DATA_W-1:0]          w_rd_mux;
    logic [DATA_W-1:0]          w_status;
    logic [DATA_W-1:0]          w_enable;
    acc_t                       w_acc;

    // Address decode and access classification for the current bus cycle.
    always_comb begin
        w_hit = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            w_hit[k] = (bus.i_Bus_Addr == ADDR_W'(k));
        end
        w_is_stat = IRQ_ON && (bus.i_Bus_Addr == STAT_ADDR);
        w_is_en   = IRQ_ON && (bus.i_Bus_Addr == EN_ADDR);
        w_rd_req  = bus.i_Bus_CS && !bus.i_Bus_Wr_Rd_n;
        w_acc     = ACC_NONE;
        if (bus.i_Bus_CS) begin
            if (bus.i_Bus_Wr_Rd_n) begin
                if (((|w_hit) && !(|(w_hit & RO_MASK))) || w_is_stat || w_is_en)
                    w_acc = ACC_WR;
                else
                    w_acc = ACC_ERR;
            end else begin
                if ((|w_hit) || w_is_stat || w_is_en)
                    w_acc = ACC_RD;
                else
                    w_acc = ACC_ERR;
            end
        end
        w_wr_hit = (w_acc == ACC_WR) ? w_hit : '0;
        w_rd_hit = (w_acc == ACC_RD) ? w_hit : '0;
    end

    // Read data select; out-of-range addresses fall through to zero.
    always_comb begin
        w_rd_mux = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (w_hit[k]) w_rd_mux = i_Regs[k*DATA_W +: DATA_W];
        end
        if (w_is_stat) w_rd_mux = w_status;
        if (w_is_en)   w_rd_mux = w_enable;
    end

    // General register storage, updated by accepted bus writes.
    always_ff @(posedge i_Bus_Clk or posedge i_Bus_Rst) begin
        if (i_Bus_Rst) begin
            r_regs <= INIT_VAL;
        end else begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (w_wr_hit[k]) r_regs[k*DATA_W +: DATA_W] <= bus.i_Bus_Wr_Data;
            end
        end
    end

    // Registered bus response and per-register strobes.
    always_ff @(posedge i_Bus_Clk or posedge i_Bus_Rst) begin
        if (i_Bus_Rst) begin
            r_wr_stb  <= '0;
            r_rd_stb  <= '0;
            r_rd_data <= '0;
            r_rd_dv   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_wr_stb <= w_wr_hit;
            r_rd_stb <= w_rd_hit;
            r_rd_dv  <= w_rd_req;
            r_err    <= (w_acc == ACC_ERR);
            if (w_rd_req) r_rd_data <= w_rd_mux;
        end
    end

`ifdef BUS_REG_IRQ_EN
    logic [DATA_W-1:0] w_w1c;
    logic              w_en_we;

    assign w_w1c   = (w_acc == ACC_WR && w_is_stat) ? bus.i_Bus_Wr_Data : '0;
    assign w_en_we = (w_acc == ACC_WR && w_is_en);

    bus_reg_irq #(
        .DATA_W (DATA_W)
    ) u_irq (
        .i_Clk     (i_Bus_Clk),
        .i_Rst     (i_Bus_Rst),
        .i_Irq_Set (i_Irq_Set),
        .i_W1c     (w_w1c),
        .i_En_We   (w_en_we),
        .i_En_Data (bus.i_Bus_Wr_Data),
        .o_Status  (w_status),
        .o_Enable  (w_enable),
        .o_Irq     (o_Irq)
    );
`else
    logic w_unused_irq_set;

    assign w_unused_irq_set = ^i_Irq_Set;
    assign w_status         = '0;
    assign w_enable         = '0;
    assign o_Irq            = 1'b0;
`endif

    assign o_Regs            = r_regs;
    assign o_Wr_Stb          = r_wr_stb;
    assign o_Rd_Stb          = r_rd_stb;
    assign bus.o_Bus_Rd_Data = r_rd_data;
    assign bus.o_Bus_Rd_DV   = r_rd_dv;
    assign bus.o_Bus_Err     = r_err;
endmodule
